// File: rtl/instr_queue.sv
// Instruction prefetch queue: DEPTH-entry FIFO between instruction memory and decode.
// First-word fall-through head, registered-only ready/valid, single-cycle flush.
module instr_queue #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  // Handshake qualifiers look only at registered count, so a pop never frees a slot same-cycle.
  assign in_ready_o  = (count_q != CNT_FULL);
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o     = count_q;

  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Flush leaves the array untouched; only reset clears it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: doc/instr_queue.md
# instr_queue

Parametrised instruction prefetch queue that replaces the single-entry instruction register between instruction memory and the decode stage. It holds up to DEPTH fetched instructions in FIFO order and presents the oldest one to decode. Valid/ready handshakes on both sides let fetch run ahead of a stalled decoder. A single-cycle flush discards all held instructions on a taken branch or jump.

## Interface
- WIDTH, 16: instruction width in bits.
- DEPTH, 4: number of entries; must be a power of two, at least 2.
- AW, $clog2(DEPTH): pointer width (derived; do not override).
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- flush  input  1  synchronous discard of all entries (from the FSM on a branch or jump).
- in_valid  input  1  fetch presents an instruction.
- in_data  input  WIDTH  instruction from memory.
- in_ready  output  1  queue accepts a push; equals (count != DEPTH).
- out_valid  output  1  head entry is valid; equals (count != 0).
- out_data  output  WIDTH  head instruction; 0 whenever out_valid = 0.
- out_ready  input  1  decode consumes the head this cycle.
- count  output  AW+1  number of valid entries, 0..DEPTH.

## Operation
- Storage: DEPTH x WIDTH register array, write pointer wr_ptr, read pointer rd_ptr (AW bits each), and a count register.
- Push: occurs when in_valid && in_ready && !flush. Writes in_data at wr_ptr, then wr_ptr increments modulo DEPTH (DEPTH-1 wraps to 0).
- Pop: occurs when out_valid && out_ready && !flush. rd_ptr increments modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- First-word fall-through: out_data is a combinational read of mem[rd_ptr], gated to 0 when count = 0.
- Full (count = DEPTH):
  - in_ready = 0; in_valid is ignored.
  - A pop in the same cycle does not enable a push. in_ready depends only on registered count, with no ready-through path.
- Empty (count = 0):
  - out_valid = 0; out_ready is ignored.
  - No bypass: a pushed instruction appears on out_data the cycle after the push.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - At the next edge, count, wr_ptr and rd_ptr go to 0. Any instruction presented on in_data that cycle is discarded.
  - Array contents are not cleared; out_data reads 0 because count = 0.
- Reset:
  - Asynchronously sets count, wr_ptr and rd_ptr to 0 and all array entries to 0.
  - Takes effect mid-operation regardless of flush or the handshakes.
- Outputs during and after reset: in_ready = 1, out_valid = 0, out_data = 0, count = 0.
- Inputs with in_valid = 0 or out_ready = 0 change no state.

## Timing
- Push-to-output latency: 1 cycle. An instruction accepted at edge N is visible on out_data / out_valid after edge N when it becomes head.
- Pop: head advances at the edge where out_valid && out_ready. The next entry is visible immediately after that edge.
- Sustained throughput: one push and one pop per cycle whenever 0 < count < DEPTH.
- flush to empty: 1 edge. in_ready = 1 and out_valid = 0 in the following cycle.
- reset release: first push may be accepted at the first rising edge with reset low.
- in_ready, out_valid and count are pure functions of registered state, with no combinational input-to-output paths. out_data depends only on rd_ptr, the array and count.

## Test plan
- Reset: assert reset for 2 cycles mid-clock with in_valid = 1, in_data = 16'hABCD -> count = 0, out_valid = 0, out_data = 0, in_ready = 1 throughout. No push recorded.
- Fill and drain (DEPTH = 4):
  - Push 16'h1111, 16'h2222, 16'h3333, 16'h4444 with out_ready = 0 -> count reaches 4, in_ready = 0. A fifth push of 16'h5555 is ignored.
  - Raise out_ready -> out_data sequence 1111, 2222, 3333, 4444; then out_valid = 0, out_data = 0.
- Simultaneous push/pop at count = 2 for 6 cycles with in_data incrementing from 16'h0010 -> count stays 2. Output order is preserved and pointers wrap past 3 without loss.
- Full plus pop: at count = 4, in_valid = 1 and out_ready = 1 -> head pops, no push, count = 3. Next cycle in_ready = 1.
- Flush priority: at count = 3, assert flush with in_valid = 1, out_ready = 1, in_data = 16'hBEEF -> next cycle count = 0, out_valid = 0. A subsequent push of 16'h7777 appears as head one cycle later.
- Reset mid-stream: at count = 2, assert reset asynchronously between edges -> count, out_valid and out_data go to 0 before the next edge. Queue operates normally after release.
